stream_max_pool: RTL and testbench

Streaming, parametrised max-pooling stage for the conv_net datapath. It consumes feature-map pixels in raster order over a valid/ready handshake, with all channels of one pixel packed in each beat. It emits one pooled pixel per non-overlapping scale×scale window. It sits between a convolution stage and the next layer and replaces whole-frame combinational pooling with a single-row partial-result buffer, so area no longer scales with the full frame.

---
 rtl/stream_max_pool.sv | 161 ++++++++++++++++
 tb/tb_stream_max_pool.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_max_pool.sv
// stream_max_pool: streaming non-overlapping scale x scale pooling stage.
//
// Pixels arrive in raster order, one beat per pixel, with all channels packed
// in the beat. A per-channel horizontal partial (hacc) folds the pixels of one
// window row. A single line buffer of datawidth/scale entries carries the
// vertical partial between window rows. Only the window's last pixel produces
// an output beat, so no full-frame storage is needed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_data = one packed pixel
//   out_valid/out_ready   output handshake, out_data = one pooled pixel
//   frame_done            high on the handshake of the last pooled pixel of a frame
//   mode                  (POOL_AVG_EN only) 0 = max pooling, 1 = average pooling
//
// Optional feature macro: POOL_AVG_EN. When it is defined, the mode port and
// the average path are added; scale must then be a power of two.
module stream_max_pool #(
  parameter int unsigned bitwidth    = 8,
  parameter int unsigned datawidth   = 24,
  parameter int unsigned dataheight  = 24,
  parameter int unsigned datachannel = 2,
  parameter int unsigned scale       = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [bitwidth*datachannel-1:0] in_data,
`ifdef POOL_AVG_EN
  input  logic                            mode,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [bitwidth*datachannel-1:0] out_data,
  output logic                            frame_done
);

  localparam int unsigned GridW = datawidth / scale;
  localparam int unsigned GridH = dataheight / scale;
  localparam int unsigned SW    = $clog2(scale);
  localparam int unsigned GWW   = (GridW > 1) ? $clog2(GridW) : 1;
  localparam int unsigned GHW   = (GridH > 1) ? $clog2(GridH) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned Shift = 2 * SW;
  // Wide enough to hold the sum of scale*scale samples.
  localparam int unsigned AW    = bitwidth + Shift;
`else
  localparam int unsigned AW    = bitwidth;
`endif
  localparam int unsigned DW    = bitwidth * datachannel;
  localparam int unsigned AccW  = AW * datachannel;

  localparam logic [SW-1:0]  SubLast    = SW'(scale - 1);
  localparam logic [GWW-1:0] ColBlkLast = GWW'(GridW - 1);
  localparam logic [GHW-1:0] RowBlkLast = GHW'(GridH - 1);

  // Position: col = cblk*scale + hcnt, row = rblk*scale + vcnt.
  logic [SW-1:0]   hcnt_q, vcnt_q;
  logic [GWW-1:0]  cblk_q;
  logic [GHW-1:0]  rblk_q;
  logic [AccW-1:0] hacc_q;
  logic [AccW-1:0] lbuf_q [GridW];
  logic            out_valid_q, out_last_q;
  logic [DW-1:0]   out_data_q;

  logic            accept;
  logic            h_first, h_last, v_first, v_last, c_last, r_last;
  logic [AccW-1:0] lb_rd, h_all, v_all;
  logic [DW-1:0]   res;

  function automatic logic [AW-1:0] umax(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = out_valid_q && out_ready && out_last_q;

  assign h_first = (hcnt_q == '0);
  assign h_last  = (hcnt_q == SubLast);
  assign v_first = (vcnt_q == '0);
  assign v_last  = (vcnt_q == SubLast);
  assign c_last  = (cblk_q == ColBlkLast);
  assign r_last  = (rblk_q == RowBlkLast);
  assign lb_rd   = lbuf_q[cblk_q];

  // The current beat is folded in combinationally, so the line-buffer entry
  // and hacc never need a read-after-write bypass.
  always_comb begin
    h_all = '0;
    v_all = '0;
    res   = '0;
    for (int c = 0; c < int'(datachannel); c++) begin
      logic [AW-1:0] px, ha, lb, hv, vv;
      px = AW'(in_data[c*bitwidth +: bitwidth]);
      ha = hacc_q[c*AW +: AW];
      lb = lb_rd[c*AW +: AW];
`ifdef POOL_AVG_EN
      if (mode) begin
        hv = h_first ? px : ha + px;
        vv = v_first ? hv : lb + hv;
        res[c*bitwidth +: bitwidth] = bitwidth'(vv >> Shift);
      end else begin
        hv = h_first ? px : umax(ha, px);
        vv = v_first ? hv : umax(lb, hv);
        res[c*bitwidth +: bitwidth] = bitwidth'(vv);
      end
`else
      hv = h_first ? px : umax(ha, px);
      vv = v_first ? hv : umax(lb, hv);
      res[c*bitwidth +: bitwidth] = vv;
`endif
      h_all[c*AW +: AW] = hv;
      v_all[c*AW +: AW] = vv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      cblk_q      <= '0;
      rblk_q      <= '0;
      hacc_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        hacc_q <= h_all;
        hcnt_q <= h_last ? '0 : hcnt_q + SW'(1);
        if (h_last) begin
          cblk_q <= c_last ? '0 : cblk_q + GWW'(1);
          if (c_last) begin
            vcnt_q <= v_last ? '0 : vcnt_q + SW'(1);
            if (v_last) rblk_q <= r_last ? '0 : rblk_q + GHW'(1);
          end
        end
      end
      // A new window result replaces the held one; in_ready guarantees the
      // held one is being taken this cycle.
      if (accept && h_last && v_last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        out_last_q  <= c_last && r_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Line buffer has no reset: each entry is written on the first row of a
  // window band before it is read on later rows.
  always_ff @(posedge clk) begin
    if (accept && h_last && !v_last) lbuf_q[cblk_q] <= v_all;
  end

endmodule

// File: tb/tb_stream_max_pool.sv
module tb_stream_max_pool;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, frame_done;
  logic [15:0] out_data;
`ifdef POOL_AVG_EN
  logic        mode = 1'b0;
`endif

  stream_max_pool #(
    .bitwidth(8), .datawidth(4), .dataheight(4), .datachannel(2), .scale(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef POOL_AVG_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int in_acc = 0, stalls = 0, fd_cnt = 0, fd_stray = 0;
  logic [15:0] got [$];
  int          fd_pos [$];
  // ch1 in the upper byte: ramp pixel i = {255-i, i}
  logic [15:0] exp_max [4] = '{16'hFF05, 16'hFD07, 16'hF70D, 16'hF50F};
  logic [15:0] exp_avg [4] = '{16'hFC02, 16'hFA04, 16'hF40A, 16'hF20C};

  always @(posedge clk) cyc <= cyc + 1;

  // Everything is stable at the falling edge for the handshake on the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) in_acc++;
      if (in_valid && !in_ready) stalls++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_done) begin
        fd_cnt++;
        fd_pos.push_back(got.size());
        if (!(out_valid && out_ready)) fd_stray++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  function automatic logic [15:0] ramp(input int i);
    return {8'(255 - i), 8'(i)};
  endfunction

  task automatic drive(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("stall_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_stats();
    got.delete();
    fd_pos.delete();
    fd_cnt = 0; in_acc = 0; stalls = 0; fd_stray = 0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input int base, input logic use_avg);
    for (int k = 0; k < 4; k++) begin
      if (base + k < got.size())
        check($sformatf("%s_out%0d", tag, k), 32'(got[base + k]),
              32'(use_avg ? exp_avg[k] : exp_max[k]));
      else
        check($sformatf("%s_missing%0d", tag, k), 32'(got.size()), 32'(base + k + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp frame, full throughput; out_valid follows each window-completing beat.
    clear_stats();
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      drive(ramp(i));
      check($sformatf("lat%0d", i), 32'(out_valid),
            32'((i == 5 || i == 7 || i == 13 || i == 15) ? 1 : 0));
    end
    check("b2b_cycles", 32'(cyc - c0), 32'd16);
    drain();
    check("ramp_count", 32'(got.size()), 32'd4);
    check_seq("ramp", 0, 1'b0);
    check("ramp_fd_cnt", 32'(fd_cnt), 32'd1);
    if (fd_pos.size() > 0) check("ramp_fd_pos", 32'(fd_pos[0]), 32'd4);
    check("ramp_fd_stray", 32'(fd_stray), 32'd0);
    check("b2b_stalls", 32'(stalls), 32'd0);
    check("ramp_accepted", 32'(in_acc), 32'd16);

    // Backpressure after the first output.
    clear_stats();
    fork
      for (int i = 0; i < 16; i++) drive(ramp(i));
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_seen", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_hold", 32'(out_data), 32'h0000FF05);
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(got.size()), 32'd4);
    check_seq("bp", 0, 1'b0);
    check("bp_accepted", 32'(in_acc), 32'd16);
    check("bp_stalled", 32'(stalls > 0), 32'd1);

    // Reset mid-frame with an output pending.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(ramp(i));
    check("mid_pending", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("mid_rst_valid2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 16; i++) drive(16'h8080);
    drain();
    check("const_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) check($sformatf("const_out%0d", k), 32'(got[k]), 32'h00008080);
    check("const_fd_cnt", 32'(fd_cnt), 32'd1);

    // Two frames without a gap.
    clear_stats();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) drive(ramp(i));
    drain();
    check("two_count", 32'(got.size()), 32'd8);
    check_seq("two_f0", 0, 1'b0);
    check_seq("two_f1", 4, 1'b0);
    check("two_fd_cnt", 32'(fd_cnt), 32'd2);
    if (fd_pos.size() > 1) begin
      check("two_fd_pos0", 32'(fd_pos[0]), 32'd4);
      check("two_fd_pos1", 32'(fd_pos[1]), 32'd8);
    end
    check("two_fd_stray", 32'(fd_stray), 32'd0);
    check("two_stalls", 32'(stalls), 32'd0);

`ifdef POOL_AVG_EN
    // Average pooling on the ramp frame.
    mode = 1'b1;
    clear_stats();
    for (int i = 0; i < 16; i++) drive(ramp(i));
    drain();
    check("avg_count", 32'(got.size()), 32'd4);
    check_seq("avg", 0, 1'b1);
    mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
